rsi_order_gen: RTL and testbench

Downstream stage of the RSI threshold comparator. Consumes the comparator's two-bit buy/sell/hold decision, one decision per qualified sample. A decision becomes an order only after it repeats for a configurable number of consecutive samples and matches the current position. The block emits orders over a valid/ready handshake, tracks a flat/long position, and enforces a cooldown after every accepted order before the next decision is considered.

---
 rtl/rsi_order_gen.sv | 116 +++++++++++
 tb/tb_rsi_order_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rsi_order_gen.sv
// Order generator behind the RSI comparator: confirms repeated buy/sell
// decisions, presents one order over valid/ready, then applies a cooldown.
//
// state | meaning
// IDLE  | counting consecutive actionable samples toward CONFIRM
// ISSUE | order presented, waiting for order_ready
// COOL  | post-acceptance cooldown, samples ignored
module rsi_order_gen #(
    parameter int CONFIRM   = 3,
    parameter int COOLDOWN  = 16,
    parameter int QTY_W     = 16,
    parameter int ORDER_QTY = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic             sig_buy,
    input  logic             sig_hold,
    output logic             order_valid,
    output logic             order_side,
    output logic [QTY_W-1:0] order_qty,
    input  logic             order_ready,
    output logic             position_long,
    output logic [7:0]       invalid_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;

    localparam logic [7:0]       CONF_LAST = 8'(CONFIRM - 1);
    localparam logic [15:0]      COOL_LOAD = 16'(COOLDOWN);
    localparam logic [QTY_W-1:0] QTY       = QTY_W'(ORDER_QTY);
    localparam bit               NO_COOL   = (COOLDOWN == 0);

    state_t      state, state_next;
    logic [7:0]  conf_cnt, conf_next;
    logic [15:0] cool_cnt, cool_next;
    logic        side_q, side_next;
    logic        pos_next;

    logic is_buy, is_sell, is_bad, actionable;

    // Illegal code 11 decodes as neither buy nor sell, so it behaves as HOLD.
    assign is_buy     = sig_buy & ~sig_hold;
    assign is_sell    = ~sig_buy & ~sig_hold;
    assign is_bad     = sig_buy & sig_hold;
    assign actionable = sample_valid & ((is_buy & ~position_long) | (is_sell & position_long));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            conf_cnt      <= 8'd0;
            cool_cnt      <= 16'd0;
            side_q        <= 1'b0;
            position_long <= 1'b0;
        end else begin
            state         <= state_next;
            conf_cnt      <= conf_next;
            cool_cnt      <= cool_next;
            side_q        <= side_next;
            position_long <= pos_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid_cnt <= 8'd0;
        end else if (sample_valid && is_bad && invalid_cnt != 8'hFF) begin
            invalid_cnt <= invalid_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        conf_next  = conf_cnt;
        cool_next  = cool_cnt;
        side_next  = side_q;
        pos_next   = position_long;
        case (state)
            IDLE: begin
                if (actionable) begin
                    if (conf_cnt >= CONF_LAST) begin
                        side_next  = is_buy;
                        conf_next  = 8'd0;
                        state_next = ISSUE;
                    end else begin
                        conf_next = conf_cnt + 8'd1;
                    end
                end else if (sample_valid) begin
                    conf_next = 8'd0;
                end
            end
            ISSUE: begin
                if (order_ready) begin
                    pos_next   = side_q;
                    cool_next  = COOL_LOAD;
                    state_next = NO_COOL ? IDLE : COOL;
                end
            end
            COOL: begin
                // Leaving on the 1->0 step makes IDLE start exactly COOLDOWN cycles after acceptance.
                if (cool_cnt != 16'd0) begin
                    cool_next = cool_cnt - 16'd1;
                end
                if (cool_cnt <= 16'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign order_valid = (state == ISSUE);
    assign order_side  = side_q;
    assign order_qty   = order_valid ? QTY : '0;

endmodule

// File: tb/tb_rsi_order_gen.sv
// Directed bench for rsi_order_gen: expected orders are queued when the
// confirming sample is driven and checked when order_valid rises.
module tb_rsi_order_gen;

    localparam logic [1:0] BUY  = 2'b10;
    localparam logic [1:0] SELL = 2'b00;
    localparam logic [1:0] HOLD = 2'b01;
    localparam logic [1:0] ILL  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic        sig_buy;
    logic        sig_hold;
    logic        order_valid;
    logic        order_side;
    logic [15:0] order_qty;
    logic        order_ready;
    logic        position_long;
    logic [7:0]  invalid_cnt;

    int   tests  = 0;
    int   failed = 0;
    logic exp_q[$];
    logic prev_valid = 1'b0;
    logic es;

    always #5 clk = ~clk;

    rsi_order_gen #(
        .CONFIRM  (3),
        .COOLDOWN (16),
        .QTY_W    (16),
        .ORDER_QTY(100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sig_buy      (sig_buy),
        .sig_hold     (sig_hold),
        .order_valid  (order_valid),
        .order_side   (order_side),
        .order_qty    (order_qty),
        .order_ready  (order_ready),
        .position_long(position_long),
        .invalid_cnt  (invalid_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; observe after the next falling edge.
    task automatic cyc(input logic v, input logic [1:0] code, input logic rdy);
        sample_valid = v;
        {sig_buy, sig_hold} = code;
        order_ready = rdy;
        @(negedge clk);
        if (order_valid && !prev_valid) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                failed++;
                $error("FAIL unexpected_order: observed order side=%0d expected no order", order_side);
            end
            if (exp_q.size() != 0) begin
                es = exp_q.pop_front();
                check("order_side", {31'd0, order_side}, {31'd0, es});
                check("order_qty", {16'd0, order_qty}, 32'd100);
            end
        end
        prev_valid = order_valid;
    endtask

    initial begin
        rst_n = 1'b0;
        sample_valid = 1'b0;
        sig_buy = 1'b0;
        sig_hold = 1'b0;
        order_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, order_valid}, 32'd0);
        check("rst_side", {31'd0, order_side}, 32'd0);
        check("rst_qty", {16'd0, order_qty}, 32'd0);
        check("rst_pos", {31'd0, position_long}, 32'd0);
        check("rst_inv", {24'd0, invalid_cnt}, 32'd0);
        rst_n = 1'b1;

        // Three BUYs with ready already high: order next cycle, accepted in one cycle.
        cyc(1, BUY, 1);
        cyc(1, BUY, 1);
        check("t1_no_early", {31'd0, order_valid}, 32'd0);
        exp_q.push_back(1'b1);
        cyc(1, BUY, 1);
        check("t1_latency", {31'd0, order_valid}, 32'd1);
        cyc(0, HOLD, 1);
        check("t1_accepted", {31'd0, order_valid}, 32'd0);
        check("t1_pos_long", {31'd0, position_long}, 32'd1);
        for (int i = 0; i < 16; i++) cyc(0, HOLD, 0);

        // Long: BUYs are not actionable; SELLs are.
        for (int i = 0; i < 3; i++) cyc(1, BUY, 0);
        check("t3_no_buy_when_long", {31'd0, order_valid}, 32'd0);
        cyc(1, SELL, 0);
        cyc(1, SELL, 0);
        exp_q.push_back(1'b0);
        cyc(1, SELL, 0);
        check("t3_sell_issued", {31'd0, order_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, HOLD, 0);
            check("stall_valid", {31'd0, order_valid}, 32'd1);
            check("stall_side", {31'd0, order_side}, 32'd0);
            check("stall_qty", {16'd0, order_qty}, 32'd100);
        end
        cyc(0, HOLD, 1);
        check("t4_accepted", {31'd0, order_valid}, 32'd0);
        check("t4_pos_flat", {31'd0, position_long}, 32'd0);
        // Actionable samples for the whole 16-cycle cooldown must not count.
        for (int i = 0; i < 16; i++) begin
            cyc(1, BUY, 0);
            check("cool_no_order", {31'd0, order_valid}, 32'd0);
        end

        // First eligible sample is right here; HOLD breaks the run.
        cyc(1, BUY, 0);
        cyc(1, BUY, 0);
        cyc(1, HOLD, 0);
        cyc(1, BUY, 0);
        cyc(1, BUY, 0);
        check("t2_hold_restart", {31'd0, order_valid}, 32'd0);
        exp_q.push_back(1'b1);
        cyc(1, BUY, 0);
        check("t2_issued", {31'd0, order_valid}, 32'd1);
        cyc(0, HOLD, 1);
        check("t2_pos_long", {31'd0, position_long}, 32'd1);

        // Illegal codes count in any state (cooldown included) and saturate.
        for (int i = 0; i < 10; i++) cyc(1, ILL, 0);
        check("inv_10", {24'd0, invalid_cnt}, 32'd10);
        for (int i = 0; i < 3; i++) cyc(0, ILL, 0);
        check("inv_needs_valid", {24'd0, invalid_cnt}, 32'd10);
        for (int i = 0; i < 290; i++) cyc(1, ILL, 0);
        check("inv_saturated", {24'd0, invalid_cnt}, 32'd255);
        check("inv_no_order", {31'd0, order_valid}, 32'd0);
        check("inv_pos_kept", {31'd0, position_long}, 32'd1);

        // Reset in the middle of an issued SELL order.
        cyc(1, SELL, 0);
        cyc(1, SELL, 0);
        exp_q.push_back(1'b0);
        cyc(1, SELL, 0);
        check("t6_issued", {31'd0, order_valid}, 32'd1);
        cyc(0, HOLD, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_drop", {31'd0, order_valid}, 32'd0);
        check("t6_pos", {31'd0, position_long}, 32'd0);
        check("t6_inv", {24'd0, invalid_cnt}, 32'd0);
        check("t6_qty", {16'd0, order_qty}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_valid = order_valid;
        check("t6_not_represented", {31'd0, order_valid}, 32'd0);

        // Gaps without sample_valid keep the confirmation count.
        cyc(1, BUY, 0);
        cyc(0, SELL, 0);
        cyc(1, BUY, 0);
        check("t6_gap_no_early", {31'd0, order_valid}, 32'd0);
        exp_q.push_back(1'b1);
        cyc(1, BUY, 0);
        check("t6_fresh_order", {31'd0, order_valid}, 32'd1);
        cyc(0, HOLD, 1);
        check("t6_pos_long", {31'd0, position_long}, 32'd1);
        cyc(0, HOLD, 0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
